// File: rtl/control_sequencer.sv
// Programmable control-word sequencer: a start pulse plays a per-mode
// microprogram from a writable table, with hold, abort and zero-gap restart.
module control_sequencer #(
   parameter int CTRL_W    = 4,
   parameter int MAX_STEPS = 8,
   parameter int MODE_W    = 1,
   parameter int STEP_W    = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [MODE_W-1:0] mode,
   input  logic              hold,
   input  logic              abort,
   input  logic              cfg_we,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic [STEP_W-1:0] cfg_step,
   input  logic [CTRL_W-1:0] cfg_data,
   input  logic              cfg_last,
   output logic [CTRL_W-1:0] out,
   output logic              d,
   output logic              busy,
   output logic [STEP_W-1:0] step
);
   localparam int NUM_MODES = 1 << MODE_W;
   localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(MAX_STEPS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [STEP_W-1:0] step_q, step_nxt;
   logic [MODE_W-1:0] mode_l, mode_nxt;
   logic [CTRL_W-1:0] word_tbl [NUM_MODES][MAX_STEPS];
   logic              last_tbl [NUM_MODES][MAX_STEPS];
   logic [CTRL_W-1:0] cur_word;
   logic              cur_last;
   logic              final_step;

   function automatic logic [CTRL_W-1:0] default_word(input int m, input int s);
      case (s)
         0:       default_word = CTRL_W'(4'b0010);
         1:       default_word = CTRL_W'(4'b0110);
         2:       default_word = ((m & 1) == 0) ? CTRL_W'(4'b1010) : CTRL_W'(4'b1011);
         default: default_word = '0;
      endcase
   endfunction

   // Unused entries default to last=1 so a stray mode can never run past them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int m = 0; m < NUM_MODES; m++) begin
            for (int s = 0; s < MAX_STEPS; s++) begin
               word_tbl[m][s] <= default_word(m, s);
               last_tbl[m][s] <= (s >= 2);
            end
         end
      end else if (cfg_we && state == IDLE && int'(cfg_step) < MAX_STEPS) begin
         word_tbl[cfg_mode][cfg_step] <= cfg_data;
         last_tbl[cfg_mode][cfg_step] <= cfg_last;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         step_q <= '0;
         mode_l <= '0;
      end else begin
         state  <= state_nxt;
         step_q <= step_nxt;
         mode_l <= mode_nxt;
      end
   end

   assign cur_word   = word_tbl[mode_l][step_q];
   assign cur_last   = last_tbl[mode_l][step_q];
   assign final_step = cur_last || (step_q == LAST_IDX);
   assign step       = step_q;

   always_comb begin
      state_nxt = state;
      step_nxt  = step_q;
      mode_nxt  = mode_l;
      out       = '0;
      d         = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mode_nxt  = mode;
               step_nxt  = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            out  = cur_word;
            busy = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               step_nxt  = '0;
            end else if (!hold) begin
               if (!final_step) begin
                  step_nxt = step_q + 1'b1;
               end else begin
                  // Completing step: a concurrent start relaunches with no idle gap.
                  d        = !reset;
                  step_nxt = '0;
                  if (start) mode_nxt = mode;
                  else       state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            step_nxt  = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: queue-based program model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_control_sequencer;
   localparam int CTRL_W    = 4;
   localparam int MAX_STEPS = 8;
   localparam int MODE_W    = 1;
   localparam int STEP_W    = 3;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [MODE_W-1:0] mode = '0;
   logic              hold = 1'b0;
   logic              abort = 1'b0;
   logic              cfg_we = 1'b0;
   logic [MODE_W-1:0] cfg_mode = '0;
   logic [STEP_W-1:0] cfg_step = '0;
   logic [CTRL_W-1:0] cfg_data = '0;
   logic              cfg_last = 1'b0;
   logic [CTRL_W-1:0] out;
   logic              d;
   logic              busy;
   logic [STEP_W-1:0] step;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   always #5 clock = ~clock;

   control_sequencer #(
      .CTRL_W(CTRL_W), .MAX_STEPS(MAX_STEPS), .MODE_W(MODE_W), .STEP_W(STEP_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .mode(mode), .hold(hold),
      .abort(abort), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
      .cfg_data(cfg_data), .cfg_last(cfg_last), .out(out), .d(d), .busy(busy),
      .step(step)
   );

   // Model: the remaining beats of the running program as a queue.
   typedef struct {
      logic [CTRL_W-1:0] word;
      int                idx;
      bit                fin;
   } beat_t;

   beat_t             prog_q[$];
   logic [CTRL_W-1:0] m_word [2][MAX_STEPS];
   bit                m_last [2][MAX_STEPS];

   function automatic void load_defaults();
      for (int m = 0; m < 2; m++) begin
         for (int s = 0; s < MAX_STEPS; s++) begin
            m_word[m][s] = '0;
            m_last[m][s] = 1'b1;
         end
         m_word[m][0] = 4'b0010; m_last[m][0] = 1'b0;
         m_word[m][1] = 4'b0110; m_last[m][1] = 1'b0;
         m_word[m][2] = (m == 0) ? 4'b1010 : 4'b1011;
      end
   endfunction

   function automatic void launch(input int m);
      bit fin;
      prog_q.delete();
      for (int s = 0; s < MAX_STEPS; s++) begin
         fin = m_last[m][s] || (s == MAX_STEPS - 1);
         prog_q.push_back('{m_word[m][s], s, fin});
         if (fin) break;
      end
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         prog_q.delete();
         load_defaults();
      end else if (prog_q.size() == 0) begin
         if (cfg_we && cfg_step < MAX_STEPS) begin
            m_word[cfg_mode][cfg_step] = cfg_data;
            m_last[cfg_mode][cfg_step] = cfg_last;
         end
         if (start) launch(int'(mode));
      end else if (abort) begin
         prog_q.delete();
      end else if (!hold) begin
         if (prog_q[0].fin) begin
            if (start) launch(int'(mode));
            else prog_q.delete();
         end else begin
            void'(prog_q.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      logic [CTRL_W-1:0] e_out;
      bit                e_d;
      bit                e_busy;
      int                e_step;
      if (check_en) begin
         e_out = '0; e_d = 1'b0; e_busy = 1'b0; e_step = 0;
         if (prog_q.size() != 0) begin
            e_out  = prog_q[0].word;
            e_busy = 1'b1;
            e_step = prog_q[0].idx;
            e_d    = !reset && !abort && !hold && prog_q[0].fin;
         end
         vectors++;
         if (out !== e_out || d !== e_d || busy !== e_busy || step !== STEP_W'(e_step)) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t: got out=%b d=%b busy=%b step=%0d, want out=%b d=%b busy=%b step=%0d",
                     $time, out, d, busy, step, e_out, e_d, e_busy, e_step);
         end
      end
   end

   task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic neg();
      @(negedge clock);
   endtask

   initial begin
      tick(); tick();
      reset = 1'b0;
      check_en = 1'b1;
      neg();
      lit("reset_out", 8'(out), 8'b0000);
      lit("reset_busy", 8'(busy), 8'd0);
      lit("reset_step", 8'(step), 8'd0);

      // default program, mode 0
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      neg(); lit("def0_w0", 8'(out), 8'b0010); lit("def0_d0", 8'(d), 8'd0);
      tick();
      neg(); lit("def0_w1", 8'(out), 8'b0110);
      tick();
      neg(); lit("def0_w2", 8'(out), 8'b1010); lit("def0_d2", 8'(d), 8'd1);
      tick();
      neg(); lit("def0_idle_busy", 8'(busy), 8'd0); lit("def0_idle_out", 8'(out), 8'd0);

      // mode 1, mode input changed during run
      mode = 1'b1; start = 1'b1; tick(); start = 1'b0; mode = 1'b0;
      tick(); tick();
      neg(); lit("def1_w2", 8'(out), 8'b1011);
      tick(); tick();

      // mode latch: start in mode 0 then move mode to 1
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0; mode = 1'b1;
      tick(); tick();
      neg(); lit("latch_w2", 8'(out), 8'b1010);
      tick(); tick();

      // hold for three cycles on step 1
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      tick();
      hold = 1'b1;
      neg(); lit("hold_step", 8'(step), 8'd1); lit("hold_d", 8'(d), 8'd0);
      tick(); tick();
      neg(); lit("hold_w", 8'(out), 8'b0110);
      tick(); hold = 1'b0;
      neg(); lit("hold_w_4th", 8'(out), 8'b0110);
      tick();
      neg(); lit("hold_w2", 8'(out), 8'b1010); lit("hold_d2", 8'(d), 8'd1);
      tick();

      // abort on step 1, then a full run
      start = 1'b1; tick(); start = 1'b0;
      tick(); abort = 1'b1;
      neg(); lit("abort_d", 8'(d), 8'd0);
      tick(); abort = 1'b0;
      neg(); lit("abort_busy", 8'(busy), 8'd0); lit("abort_out", 8'(out), 8'd0);
      start = 1'b1; tick(); start = 1'b0;
      repeat (4) tick();

      // reprogram mode 0 with eight steps
      for (int s = 0; s < 8; s++) begin
         cfg_we = 1'b1; cfg_mode = 1'b0; cfg_step = STEP_W'(s);
         cfg_data = CTRL_W'(s + 1); cfg_last = (s == 7);
         tick();
      end
      cfg_we = 1'b0;
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      cfg_we = 1'b1; cfg_mode = 1'b0; cfg_step = '0; cfg_data = 4'b1111; cfg_last = 1'b1;
      tick(); cfg_we = 1'b0;
      repeat (4) tick();
      neg(); lit("prog_w7", 8'(out), 8'b1000); lit("prog_d7", 8'(d), 8'd1);
      tick();
      start = 1'b1; tick(); start = 1'b0;
      neg(); lit("run_write_ignored", 8'(out), 8'b0001);
      repeat (8) tick();

      // zero-gap restart with start held high
      mode = 1'b1; start = 1'b1; tick();
      tick(); tick();
      neg(); lit("restart_d1", 8'(d), 8'd1);
      tick();
      neg(); lit("restart_busy", 8'(busy), 8'd1); lit("restart_w0", 8'(out), 8'b0010);
      tick(); tick();
      neg(); lit("restart_d2", 8'(d), 8'd1);
      start = 1'b0; tick(); tick();

      // reset on step 2 restores default table
      mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      reset = 1'b1;
      neg(); lit("reset_mid_d", 8'(d), 8'd0);
      tick(); reset = 1'b0;
      neg(); lit("reset_mid_busy", 8'(busy), 8'd0);
      start = 1'b1; tick(); start = 1'b0;
      neg(); lit("reset_tbl_w0", 8'(out), 8'b0010);
      repeat (3) tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom % 97) == 0;
         start    = ($urandom % 3) == 0;
         hold     = ($urandom % 6) == 0;
         abort    = ($urandom % 14) == 0;
         mode     = MODE_W'($urandom);
         cfg_we   = ($urandom % 4) == 0;
         cfg_mode = MODE_W'($urandom);
         cfg_step = STEP_W'($urandom);
         cfg_data = CTRL_W'($urandom);
         cfg_last = ($urandom % 3) == 0;
         tick();
      end
      reset = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      repeat (10) tick();
      neg();
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Programmable multi-step control-word sequencer. It is the parametrised successor of the fixed four-state start/mode control unit. A start pulse launches a per-mode microprogram of up to MAX_STEPS control words held in a writable table, with hold, abort and back-to-back restart. It sits between the top-level start/mode inputs and the datapath load/select strobes.

Parameters:
CTRL_W, 4, width of each control word driven on out
MAX_STEPS, 8, table depth per mode (steps 0..MAX_STEPS-1)
MODE_W, 1, mode select width; table holds 2**MODE_W programs
STEP_W, 3, step index width; must be >= clog2(MAX_STEPS)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  launch request; sampled in IDLE or in the completing step
mode  in  MODE_W  program select, latched when start is accepted
hold  in  1  freeze current step (out and step held)
abort  in  1  terminate program, return to IDLE
cfg_we  in  1  table write enable
cfg_mode  in  MODE_W  table write mode index
cfg_step  in  STEP_W  table write step index
cfg_data  in  CTRL_W  control word to write
cfg_last  in  1  last-step flag to write
out  out  CTRL_W  current control word
d  out  1  done strobe, high in the completing cycle
busy  out  1  high while in RUN
step  out  STEP_W  current step index (0 in IDLE)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, RUN. Registers: state, step, mode_l, table[2**MODE_W][MAX_STEPS] of {last, word}.
- Reset: state=IDLE, step=0, mode_l=0.
  - Table reloads the default program: step0=0010, step1=0110, step2=1010 (last) for even modes; step2=1011 (last) for odd modes.
  - All other entries reset to word 0 with last=1.
- Outputs are combinational from registers:
  - IDLE: out=0, d=0, busy=0, step=0.
  - RUN: out=table[mode_l][step].word, busy=1.
- IDLE: if start, then mode_l<=mode, step<=0, state<=RUN. Otherwise stay.
- RUN, priority order: reset > abort > hold > advance.
  - abort: state<=IDLE, step<=0 at next edge; d=0 in that cycle.
  - hold (no abort): step and state unchanged; d=0.
  - Advance: the entry is final when its last=1 or step==MAX_STEPS-1.
    - Not final: step<=step+1.
    - Final: d=1 this cycle. If start is also high, mode_l<=mode, step<=0, stay in RUN (zero-gap restart). Otherwise state<=IDLE.
- start while RUN and not in the completing cycle: ignored.
- Latency: start high in cycle k gives step 0 on out in cycle k+1. A program of N steps gives d=1 in cycle k+N and IDLE in cycle k+N+1.
- mode is latched only at accept. Changes on mode during RUN have no effect.
- Table writes: cfg_we is honoured only when state==IDLE (in RUN it is ignored, no error).
  - A write to [cfg_mode][cfg_step] lands at the edge.
  - A start accepted in the same cycle sees the new entry at step 0.
- cfg_step >= MAX_STEPS: write ignored.
- Reset mid-program: IDLE next edge, table restored to defaults, d=0.

Test Plan:
- Default program: reset, then start=1 mode=0 for one cycle → out 0010, 0110, 1010 on the next three cycles; d=1 only on the third; busy 3 cycles; then out=0. Repeat with mode=1 → third word 1011.
- Mode latch: start with mode=0, toggle mode to 1 during RUN → third word remains 1010.
- Hold: assert hold on cycle 2 for 3 cycles → out stays 0110 for 4 cycles total, d delayed 3 cycles, step=1 throughout the hold.
- Abort: abort on step1 → next cycle out=0, busy=0, d never asserted; a subsequent start runs the full program.
- Reprogram: in IDLE write mode0 steps 0..7 = 0001..1000 with last only on step7 → start gives 8 words, d on the 8th. A write attempted during RUN leaves the table unchanged (verified on the next run).
- Restart and reset: start held high continuously → d pulses every 3 cycles with no IDLE gap. Reset asserted on step2 → IDLE next cycle, table back to the default program.
